// File: rtl/pause_mux.sv
// pause_mux: merges pause sources into pause_cpu and dims video after a programmable idle time.
// Optional stepped fade of the dim level is enabled by defining PAUSE_MUX_FADE_EN.
module pause_mux #(
    parameter int RW            = 3,
    parameter int GW            = 3,
    parameter int BW            = 2,
    parameter int NREQ          = 2,
    parameter int TICKS_PER_SEC = 24000000,
    parameter int DIM_SEC       = 10,
    parameter int DIM_SHIFT     = 1
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic                  user_button,
    input  logic [NREQ-1:0]       pause_request,
    input  logic                  OSD_STATUS,
    input  logic [1:0]            options,
    input  logic [RW-1:0]         r,
    input  logic [GW-1:0]         g,
    input  logic [BW-1:0]         b,
    output logic [RW+GW+BW-1:0]   rgb_out,
    output logic                  pause_cpu,
    output logic                  dim_video,
    output logic [NREQ+1:0]       pause_src
);
    localparam int PW = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;
    localparam int SW = $clog2(DIM_SEC + 1);
    localparam int LW = $clog2(DIM_SHIFT + 1);
    localparam logic [1:0] RUN = 2'd0, PAUSED = 2'd1, DIMMED = 2'd2;
    logic          btn_q, user_pause, dim, wrap;
    logic [1:0]    state;
    logic [PW-1:0] pre;
    logic [SW-1:0] sec, sec_nx;
    logic [LW-1:0] dim_level;
    assign pause_cpu = |pause_src;
    assign dim       = state == DIMMED && options[1];
    assign wrap      = state != RUN && pre == PW'(TICKS_PER_SEC - 1);
    assign sec_nx    = wrap && sec != SW'(DIM_SEC) ? sec + 1'b1 : sec;
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            btn_q      <= 1'b1;
            user_pause <= 1'b0;
            pause_src  <= '0;
            state      <= RUN;
            pre        <= '0;
            sec        <= '0;
            dim_video  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            btn_q      <= user_button;
            user_pause <= user_pause ^ (user_button & ~btn_q);
            pause_src  <= {user_pause, options[0] & OSD_STATUS, pause_request};
            pre        <= state == RUN || wrap ? '0 : pre + 1'b1;
            sec        <= state == RUN ? '0 : sec_nx;
            // DIMMED is entered on the same edge the seconds count reaches DIM_SEC
            state      <= !pause_cpu ? RUN : state == RUN ? PAUSED : sec_nx == SW'(DIM_SEC) ? DIMMED : state;
            dim_video  <= dim;
            rgb_out    <= {r >> dim_level, g >> dim_level, b >> dim_level};
        end
    end
`ifdef PAUSE_MUX_FADE_EN
    logic [LW-1:0] fade;
    always_ff @(posedge clk_sys) begin
        if (!reset_n)
            fade <= LW'(1);
        else
            fade <= state != DIMMED ? LW'(1) : wrap && fade != LW'(DIM_SHIFT) ? fade + 1'b1 : fade;
    end
    assign dim_level = dim ? fade : '0;
`else
    assign dim_level = dim ? LW'(DIM_SHIFT) : '0;
`endif
endmodule

// File: tb/tb_pause_mux.sv
// tb_pause_mux: directed and randomized checks of pause_mux against a cycle-count reference model.
module tb_pause_mux;
    localparam int T = 4, D = 2, S = 2;
    logic       clk_sys = 1'b0, reset_n, user_button, OSD_STATUS;
    logic [1:0] pause_request, options;
    logic [2:0] r, g;
    logic [1:0] b;
    logic [7:0] rgb_out;
    logic       pause_cpu, dim_video;
    logic [3:0] pause_src;
    int cmp = 0, errs = 0;

    pause_mux #(.RW(3), .GW(3), .BW(2), .NREQ(2), .TICKS_PER_SEC(T), .DIM_SEC(D), .DIM_SHIFT(S)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .user_button(user_button), .pause_request(pause_request),
        .OSD_STATUS(OSD_STATUS), .options(options), .r(r), .g(g), .b(b),
        .rgb_out(rgb_out), .pause_cpu(pause_cpu), .dim_video(dim_video), .pause_src(pause_src));

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: pause is tracked as "cycles spent paused" n; dimming is n >= D*T, fade grows one step per T cycles.
    bit         mbq, mup, mpaused, mdim, armed = 0, dimmed, pc;
    logic [3:0] msrc;
    logic [7:0] mrgb;
    int         n, lvl;
    always @(posedge clk_sys) begin
        if (!reset_n) begin
            mbq = 1; mup = 0; msrc = 0; mpaused = 0; n = 0; mdim = 0; mrgb = 0; armed = 1;
        end else begin
            dimmed = mpaused && n >= D * T;
            mdim = dimmed && options[1];
`ifdef PAUSE_MUX_FADE_EN
            lvl = mdim ? 1 + (n - D * T) / T : 0;
            if (lvl > S) lvl = S;
`else
            lvl = mdim ? S : 0;
`endif
            mrgb = {r >> lvl, g >> lvl, b >> lvl};
            pc = |msrc;
            if (!pc) begin mpaused = 0; n = 0; end
            else if (!mpaused) begin mpaused = 1; n = 0; end
            else n++;
            msrc = {mup, options[0] & OSD_STATUS, pause_request};
            mup = mup ^ (user_button & !mbq);
            mbq = user_button;
        end
    end

    always @(negedge clk_sys) if (armed) begin
        chk("pause_cpu", pause_cpu, |msrc);
        chk("pause_src", pause_src, msrc);
        chk("dim_video", dim_video, mdim);
        chk("rgb_out", rgb_out, mrgb);
    end

    task automatic step;
        @(posedge clk_sys);
        #1;
    endtask

    initial begin
        int k;
        reset_n = 0; user_button = 1; OSD_STATUS = 0; options = 2'b11; pause_request = 0;
        r = 3'b110; g = 3'b111; b = 2'b10;
        repeat (3) step;
        chk("rst_pause_cpu", pause_cpu, 0);
        chk("rst_pause_src", pause_src, 0);
        chk("rst_dim", dim_video, 0);
        chk("rst_rgb", rgb_out, 0);
        reset_n = 1; pause_request = 2'b01;
        step;
        chk("req_pause_lat", pause_cpu, 1);
        k = 0;
        while (!dim_video && k < 40) begin step; k++; end
        chk("dim_delay", k, 10);
`ifdef PAUSE_MUX_FADE_EN
        chk("dim_rgb_first", rgb_out, 8'h6D);
`else
        chk("dim_rgb_first", rgb_out, 8'h24);
`endif
        repeat (6) step;
        chk("dim_rgb_full", rgb_out, 8'h24);
        options = 2'b01; step;
        chk("opt1_clear_dim", dim_video, 0);
        chk("opt1_clear_rgb", rgb_out, 8'hDE);
        options = 2'b11; step;
        chk("opt1_set_dim", dim_video, 1);
        reset_n = 0; pause_request = 0; step;
        chk("midrst_pause", pause_cpu, 0);
        chk("midrst_src", pause_src, 0);
        chk("midrst_dim", dim_video, 0);
        chk("midrst_rgb", rgb_out, 0);
        reset_n = 1; repeat (3) step;
        chk("held_btn_no_toggle", pause_cpu, 0);
        user_button = 0; step; user_button = 1; step;
        chk("btn_lat1", pause_cpu, 0);
        step;
        chk("btn_lat2", pause_cpu, 1);
        chk("btn_src", pause_src, 4'b1000);
        user_button = 0; step; user_button = 1; step; step;
        chk("btn_untoggle", pause_cpu, 0);
        options = 2'b00; OSD_STATUS = 1; step; step;
        chk("osd_disabled", pause_cpu, 0);
        options = 2'b01; step;
        chk("osd_enabled", pause_cpu, 1);
        OSD_STATUS = 0; options = 2'b11; user_button = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(39) == 0) pause_request = 2'($urandom);
            if ($urandom_range(59) == 0) user_button = ~user_button;
            if ($urandom_range(29) == 0) OSD_STATUS = ~OSD_STATUS;
            if ($urandom_range(79) == 0) options = 2'($urandom);
            reset_n = $urandom_range(699) != 0;
            r = 3'($urandom); g = 3'($urandom); b = 2'($urandom);
            step;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
